// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga core front end.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  typedef struct packed {
    bus32_t pc;
    bus32_t instr;
  } instr_data_t;

  localparam int     FETCH_DEPTH = 2;
  localparam bus32_t PC_STEP     = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of instr_data_t with flush; used both for fetched
// words and for the PC tags of requests still waiting on memory.
module fetch_fifo
  import tartaruga_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  instr_data_t   push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output instr_data_t   head_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  instr_data_t   r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  // A full FIFO may push and pop together: the slot being read is the one
  // overwritten, and the head is consumed in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wrPtr] <= push_data_i;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (pop_i) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = (r_count != '0) ? r_mem[r_rdPtr] : '0;
  assign count_o = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, in-order imem requests, 2-entry output FIFO.
// Optional misaligned-redirect fault: define TARTARUGA_FETCH_MISALIGN_EN.
module fetch_stage
  import tartaruga_pkg::*;
#(
  parameter bus32_t RESET_PC = 32'h0000_0000,
  parameter int     DEPTH    = FETCH_DEPTH
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        redirect_valid_i,
  input  bus32_t      redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output bus32_t      imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  bus32_t      imem_rsp_data_i,
  output instr_data_t instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        fetch_misaligned_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Headroom for stale requests piling up across back-to-back redirects.
  localparam int OW = $clog2(DEPTH) + 4;

  bus32_t        r_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;

  logic          w_fault;
  bus32_t        w_redirPc;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_tagCount;
  logic          w_pop;
  logic          w_credit;
  logic          w_reqFire;
  logic          w_rspKeep;
  instr_data_t   w_tagIn;
  instr_data_t   w_tagHead;
  instr_data_t   w_pushData;

`ifdef TARTARUGA_FETCH_MISALIGN_EN
  logic r_fault;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_fault <= 1'b0;
    end else if (redirect_valid_i) begin
      r_fault <= |redirect_pc_i[1:0];
    end
  end

  assign w_fault   = r_fault;
  assign w_redirPc = redirect_pc_i;
`else
  assign w_fault   = 1'b0;
  assign w_redirPc = redirect_pc_i & ~32'd3;
`endif

  assign instr_valid_o      = (w_count != '0);
  assign w_pop              = instr_valid_o && instr_ready_i && !redirect_valid_i;
  assign fetch_misaligned_o = w_fault;

  // Tag count equals outstanding minus discard; a pop this cycle frees a
  // slot, which is what lets L=1 stream one word per cycle.
  assign w_credit = ((CW+1)'(w_tagCount) + (CW+1)'(w_count) - (CW+1)'(w_pop))
                    < (CW+1)'(DEPTH);

  assign imem_req_valid_o = rstn_i && w_credit && !redirect_valid_i && !w_fault;
  assign imem_req_addr_o  = {r_pc[31:2], 2'b00};
  assign w_reqFire        = imem_req_valid_o && imem_req_ready_i;
  assign w_rspKeep        = imem_rsp_valid_i && (r_discard == '0) && !redirect_valid_i;

  assign w_tagIn = '{pc: r_pc, instr: '0};

  always_comb begin
    w_pushData       = w_tagHead;
    w_pushData.instr = imem_rsp_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      if (redirect_valid_i) begin
        r_pc <= w_redirPc;
      end else if (w_reqFire) begin
        r_pc <= r_pc + PC_STEP;
      end
      r_outstanding <= r_outstanding + OW'(w_reqFire) - OW'(imem_rsp_valid_i);
      if (redirect_valid_i) begin
        r_discard <= r_outstanding - OW'(imem_rsp_valid_i);
      end else if (imem_rsp_valid_i && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tagFifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (w_reqFire),
    .push_data_i (w_tagIn),
    .pop_i       (w_rspKeep),
    .flush_i     (redirect_valid_i),
    .head_o      (w_tagHead),
    .count_o     (w_tagCount)
  );

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_dataFifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (w_rspKeep),
    .push_data_i (w_pushData),
    .pop_i       (w_pop),
    .flush_i     (redirect_valid_i),
    .head_o      (instr_o),
    .count_o     (w_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order memory model.
module tb_fetch_stage;
  import tartaruga_pkg::*;

  typedef struct {
    logic   redir;
    bus32_t rpc;
    logic   iready;
    logic   expRv;
    bus32_t expAddr;
    logic   expIv;
    bus32_t expPc;
  } vec_t;

  typedef struct {
    bus32_t addr;
    int     due;
  } memReq_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirValid = 1'b0;
  bus32_t      redirPc = '0;
  logic        reqValid;
  logic        reqReady = 1'b1;
  bus32_t      reqAddr;
  logic        rspValid = 1'b0;
  bus32_t      rspData = '0;
  instr_data_t instrOut;
  logic        instrValid;
  logic        instrReady = 1'b1;
  logic        misaligned;

  memReq_t memQ[$];
  int      cyc = 0;
  int      latency = 1;
  int      testsRun = 0;
  int      testsFailed = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .redirect_valid_i   (redirValid),
    .redirect_pc_i      (redirPc),
    .imem_req_valid_o   (reqValid),
    .imem_req_ready_i   (reqReady),
    .imem_req_addr_o    (reqAddr),
    .imem_rsp_valid_i   (rspValid),
    .imem_rsp_data_i    (rspData),
    .instr_o            (instrOut),
    .instr_valid_o      (instrValid),
    .instr_ready_i      (instrReady),
    .fetch_misaligned_o (misaligned)
  );

  function automatic bus32_t wordFor(input bus32_t a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory accepts on the rising edge and answers exactly latency cycles later.
  always @(posedge clk) begin
    if (!rstn) begin
      memQ.delete();
    end else if (reqValid && reqReady) begin
      memQ.push_back('{reqAddr, cyc + latency});
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (memQ.size() > 0 && memQ[0].due == cyc) begin
      rspValid = 1'b1;
      rspData  = wordFor(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      rspValid = 1'b0;
      rspData  = '0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input bus32_t rpc, input logic iready);
    @(negedge clk);
    rstn       = 1'b1;
    redirValid = redir;
    redirPc    = rpc;
    instrReady = iready;
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic expRv, input bus32_t expAddr,
                            input logic expIv, input bus32_t expPc);
    checkOutput($sformatf("%s req_valid", tag), {31'b0, reqValid}, {31'b0, expRv});
    checkOutput($sformatf("%s req_addr", tag), reqAddr, expAddr);
    checkOutput($sformatf("%s instr_valid", tag), {31'b0, instrValid}, {31'b0, expIv});
    if (expIv) begin
      checkOutput($sformatf("%s instr.pc", tag), instrOut.pc, expPc);
      checkOutput($sformatf("%s instr.word", tag), instrOut.instr, wordFor(expPc));
    end
  endtask

  task automatic resetDut(input int lat);
    @(negedge clk);
    rstn       = 1'b0;
    redirValid = 1'b0;
    redirPc    = '0;
    instrReady = 1'b1;
    latency    = lat;
    @(negedge clk);
    #1;
    checkOutput("reset req_valid", {31'b0, reqValid}, 32'd0);
    checkOutput("reset instr_valid", {31'b0, instrValid}, 32'd0);
    checkOutput("reset instr_o.pc", instrOut.pc, 32'd0);
    checkOutput("reset instr_o.instr", instrOut.instr, 32'd0);
    checkOutput("reset misaligned", {31'b0, misaligned}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[25];

    // Streaming at L=1, then a 5-cycle decode stall.
    vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010};
    vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};
    vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0014};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0018};
    vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0024, 1'b1, 32'h0000_001C};
    // Redirect with a response arriving and decode popping in the same cycle.
    vecs[15] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0028, 1'b1, 32'h0000_0020};
    vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0304, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0308, 1'b1, 32'h0000_0300};
    vecs[19] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_030C, 1'b1, 32'h0000_0304};
    // PC wrap from the top of the address space.
    vecs[20] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0310, 1'b1, 32'h0000_0308};
    vecs[21] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[22] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[23] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
    vecs[24] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};

    resetDut(1);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].redir, vecs[i].rpc, vecs[i].iready);
      checkCycle($sformatf("vec%0d", i), vecs[i].expRv, vecs[i].expAddr, vecs[i].expIv, vecs[i].expPc);
    end

    // L=3: two requests in flight when redirecting to 0x100; both are discarded.
    resetDut(3);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c1", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c2", 1'b1, 32'h0000_0004, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1);
    checkOutput("l3 c3 req_valid", {31'b0, reqValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c4", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c5", 1'b1, 32'h0000_0104, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c6", 1'b0, 32'h0000_0108, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c7", 1'b0, 32'h0000_0108, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("l3 c8", 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("l3 c9 instr_valid", {31'b0, instrValid}, 32'd1);
    checkOutput("l3 c9 instr.pc", instrOut.pc, 32'h0000_0104);

    // Redirect to a misaligned target.
    resetDut(1);
    applyStimulus(1'b1, 32'h0000_0102, 1'b1);
    checkOutput("mis c1 req_valid", {31'b0, reqValid}, 32'd0);
`ifdef TARTARUGA_FETCH_MISALIGN_EN
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis c2 misaligned", {31'b0, misaligned}, 32'd1);
    checkOutput("mis c2 req_valid", {31'b0, reqValid}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    checkOutput("mis c3 misaligned", {31'b0, misaligned}, 32'd1);
    checkOutput("mis c3 req_valid", {31'b0, reqValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis c4 misaligned", {31'b0, misaligned}, 32'd0);
    checkCycle("mis c4", 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("mis c5", 1'b1, 32'h0000_0204, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("mis c6", 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0200);
`else
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis c2 misaligned", {31'b0, misaligned}, 32'd0);
    checkCycle("mis c2", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("mis c3", 1'b1, 32'h0000_0104, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkCycle("mis c4", 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the tartaruga core, directly upstream of decode. Owns the PC, issues in-order word requests to instruction memory, buffers returned words with their PC in a 2-entry FIFO, and presents them to decode as `instr_data_t` under a valid/ready handshake. Redirects from execute (taken branch, JAL, JALR) flush the FIFO and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: FIFO entries; also the cap on outstanding plus buffered words. Power of two, ≥2.

- `clk_i`  in  1  clock, all state on rising edge.
- `rstn_i`  in  1  **synchronous, active-low reset.**
- `redirect_valid_i`  in  1  execute requests a PC change this cycle.
- `redirect_pc_i`  in  32 (`bus32_t`)  new PC.
- `imem_req_valid_o`  out  1  request valid.
- `imem_req_ready_i`  in  1  memory accepts request.
- `imem_req_addr_o`  out  32  word address, bits [1:0] always 0.
- `imem_rsp_valid_i`  in  1  response word valid; in order, latency ≥1 cycle, no backpressure.
- `imem_rsp_data_i`  in  32  instruction word.
- `instr_o`  out  `instr_data_t`  FIFO head: `pc` and `instr` fields.
- `instr_valid_o`  out  1  FIFO non-empty.
- `instr_ready_i`  in  1  decode consumes head.
- `fetch_misaligned_o`  out  1  misaligned-target fault (see Configuration).

## Operation
- State: `pc_q`, FIFO (`count_q`, `rd_ptr_q`, `wr_ptr_q`), `outstanding_q` (all requests in flight), `discard_q` (in-flight requests belonging to a flushed stream).
- Credit: `outstanding_q - discard_q + count_q < DEPTH`.
- `imem_req_valid_o = credit && !redirect_valid_i && !fault_q`; `imem_req_addr_o = pc_q`.
- Request handshake: `pc_q += 4` (32-bit wrap, 0xFFFF_FFFC → 0x0), `outstanding_q++`.
- Response: `outstanding_q--`. If `discard_q != 0` or `redirect_valid_i`, drop it and, if `discard_q != 0`, `discard_q--`. Otherwise push `{pc, word}`; the PC travels with the request in a DEPTH-entry tag queue.
- Pop on `instr_valid_o && instr_ready_i`. Push and pop in one cycle with `count_q == DEPTH` is legal; the credit rule prevents overflow.
- Redirect: `pc_q <= redirect_pc_i`, FIFO emptied, `discard_q <= outstanding_q - imem_rsp_valid_i`. Any simultaneous pop is ignored. A response arriving in the redirect cycle is dropped.
- Redirect while `discard_q != 0` recomputes `discard_q` by the same rule; the old value is not added.

## Timing
- Reset (cycle with `rstn_i == 0`): `pc_q = RESET_PC`, count/pointers/outstanding/discard = 0, `fault_q = 0`. Outputs: `imem_req_valid_o = 0`, `instr_valid_o = 0`, `instr_o = '0`, `fetch_misaligned_o = 0`.
- First request on the first cycle after reset release.
- Response latency L ⇒ `instr_valid_o` at request cycle + L + 1. FIFO output is registered.
- Redirect in cycle t ⇒ request for the new PC at t+1 if credit allows. `instr_valid_o` is low at t+1.
- Full throughput of one instruction per cycle when L = 1 and decode is always ready.
- Reset mid-stream: all in-flight responses must be quiesced by the memory side. The block treats every post-reset response as new.

## Configuration
- `TARTARUGA_FETCH_MISALIGN_EN` defined: a redirect with `redirect_pc_i[1:0] != 0` sets `fault_q`, which drives `fetch_misaligned_o`. While `fault_q` is set, requests stop. The next aligned redirect or reset clears it. `pc_q` is loaded with the faulting value so `instr_o.pc` debug/trap logic can read it from `pc_q`.
- Undefined: `redirect_pc_i[1:0]` is forced to 0, no fault logic exists, and `fetch_misaligned_o` is tied to 0.

## Structure
- In `tartaruga_pkg`: `instr_data_t` (already present), `FETCH_DEPTH` default constant, `PC_STEP = 32'd4`.
- Sub-module `fetch_fifo`: parameterised DEPTH-entry synchronous FIFO of `instr_data_t`, with push/pop/flush ports and count output. It is reused for the PC tag queue.

## Test plan
1. Reset → release, L = 1, ready = 1 → addresses 0x0, 0x4, 0x8 on consecutive cycles; `instr_o.pc` = 0x0 at cycle 3, then one per cycle.
2. `instr_ready_i = 0` for 5 cycles → at most 2 buffered plus 0 outstanding. Request valid drops, no word lost, order preserved after ready returns.
3. Two requests outstanding (L = 3), redirect to 0x100 → both old responses dropped. Next `instr_o.pc` = 0x100 with the word returned for 0x100.
4. Redirect in the same cycle as a response and a decode pop → FIFO empty next cycle, response dropped, `discard_q` = outstanding − 1.
5. `pc_q` = 0xFFFF_FFFC request accepted → next address 0x0000_0000.
6. With `TARTARUGA_FETCH_MISALIGN_EN`, redirect to 0x102 → `fetch_misaligned_o` = 1 next cycle, no requests. Redirect to 0x200 → fault clears and 0x200 is requested.
